// File: rtl/simd_sat_alu.sv
// simd_sat_alu: handshaked SIMD ALU with saturating add/sub, lane-wise padded add,
// shifter, XOR and a multi-cycle lane reduction. Results are registered behind a
// valid/ready pair and drive a {Z,V,N} flag register.
module simd_sat_alu #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned LANE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             error_o,
  output logic [2:0]       flags_o
);

  localparam int unsigned N_LANES = WIDTH / LANE_W;
  localparam int unsigned SH_W    = $clog2(WIDTH);
  // Wide enough for 2*N_LANES signed lane values, so the sum never wraps.
  localparam int unsigned ACC_W   = LANE_W + $clog2(2 * N_LANES);
  localparam int unsigned CNT_W   = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  localparam logic [2:0] OpAdd  = 3'b000;
  localparam logic [2:0] OpSub  = 3'b001;
  localparam logic [2:0] OpPadd = 3'b010;
  localparam logic [2:0] OpSll  = 3'b011;
  localparam logic [2:0] OpSra  = 3'b100;
  localparam logic [2:0] OpRor  = 3'b101;
  localparam logic [2:0] OpRed  = 3'b110;
  localparam logic [2:0] OpXor  = 3'b111;

  typedef enum logic [0:0] {StIdle, StRedAcc} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               error_q, error_d;
  logic [2:0]         flags_q, flags_d;

  // Single-cycle datapath signals
  logic [WIDTH-1:0]   b_eff, add_sum, add_sat;
  logic               add_ovf;
  logic [LANE_W:0]    lane_sum;
  logic [WIDTH-1:0]   padd_res;
  logic [N_LANES-1:0] padd_ovf;
  logic [SH_W-1:0]    sh_amt;
  logic [2*WIDTH-1:0] rot_wide;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_err;

  // Reduction step signals
  logic [LANE_W-1:0]  lane_a, lane_b;
  logic [ACC_W-1:0]   acc_step;
  logic [WIDTH-1:0]   red_res;

  logic               accept, done, done_err;
  logic [WIDTH-1:0]   done_res;

  // Combinational result of every single-cycle op, taken straight from the inputs
  always_comb begin
    b_eff    = (op_i == OpSub) ? ~b_i : b_i;
    add_sum  = a_i + b_eff + WIDTH'(op_i == OpSub);
    add_ovf  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (add_sum[WIDTH-1] != a_i[WIDTH-1]);
    add_sat  = a_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    lane_sum = '0;
    padd_res = '0;
    padd_ovf = '0;
    for (int l = 0; l < N_LANES; l++) begin
      lane_sum = {a_i[l*LANE_W+LANE_W-1], a_i[l*LANE_W +: LANE_W]}
               + {b_i[l*LANE_W+LANE_W-1], b_i[l*LANE_W +: LANE_W]};
      if (lane_sum[LANE_W] != lane_sum[LANE_W-1]) begin
        padd_ovf[l] = 1'b1;
        padd_res[l*LANE_W +: LANE_W] = lane_sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}}
                                                        : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
        padd_res[l*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
      end
    end
    sh_amt   = b_i[SH_W-1:0];
    rot_wide = {a_i, a_i} >> sh_amt;
    alu_res  = '0;
    alu_err  = 1'b0;
    unique case (op_i)
      OpAdd, OpSub: begin
        alu_res = add_ovf ? add_sat : add_sum;
        alu_err = add_ovf;
      end
      OpPadd: begin
        alu_res = padd_res;
        alu_err = |padd_ovf;
      end
      OpSll:   alu_res = a_i << sh_amt;
      OpSra:   alu_res = $signed(a_i) >>> sh_amt;
      OpRor:   alu_res = rot_wide[WIDTH-1:0];
      OpXor:   alu_res = a_i ^ b_i;
      OpRed:   alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  // One reduction step: the captured operands are shifted down so lane i is always at bit 0
  always_comb begin
    lane_a   = a_q[LANE_W-1:0];
    lane_b   = b_q[LANE_W-1:0];
    acc_step = acc_q + {{(ACC_W-LANE_W){lane_a[LANE_W-1]}}, lane_a}
                     + {{(ACC_W-LANE_W){lane_b[LANE_W-1]}}, lane_b};
    red_res  = WIDTH'($signed(acc_step));
  end

  assign in_ready_o = (state_q == StIdle) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  // FSM next state, operand capture and output register update
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    error_d     = error_q;
    flags_d     = flags_q;
    done        = 1'b0;
    done_res    = '0;
    done_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d = a_i;
          b_d = b_i;
          if (op_i == OpRed) begin
            state_d = StRedAcc;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            done     = 1'b1;
            done_res = alu_res;
            done_err = alu_err;
          end
        end
      end
      StRedAcc: begin
        acc_d = acc_step;
        a_d   = a_q >> LANE_W;
        b_d   = b_q >> LANE_W;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N_LANES - 1)) begin
          state_d  = StIdle;
          cnt_d    = '0;
          done     = 1'b1;
          done_res = red_res;
        end
      end
      default: state_d = StIdle;
    endcase
    if (done) begin
      out_valid_d = 1'b1;
      result_d    = done_res;
      error_d     = done_err;
      flags_d     = {done_res == '0, done_err, done_res[WIDTH-1]};
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      error_q     <= 1'b0;
      flags_q     <= 3'b000;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      error_q     <= error_d;
      flags_q     <= flags_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign error_o     = error_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_simd_sat_alu.sv
// tb_simd_sat_alu: random and directed stimulus against a behavioural model of the ALU.
module tb_simd_sat_alu;

  localparam int W   = 16;
  localparam int L   = 4;
  localparam int NL  = W / L;
  localparam int SHW = 4;

  logic         clk, rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, error;
  logic [2:0]   op, flags;
  logic [W-1:0] a, b, result;

  int checks = 0;
  int errs   = 0;

  simd_sat_alu #(.WIDTH(W), .LANE_W(L)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .result_o   (result),
    .error_o    (error),
    .flags_o    (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed value of the low n bits of x
  function automatic longint sval(input longint unsigned x, input int n);
    longint v;
    v = longint'(x & ((64'd1 << n) - 1));
    if (x[n-1]) v = v - (longint'(1) << n);
    return v;
  endfunction

  // Reference result from the arithmetic definition of each op
  task automatic ref_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic e);
    longint s, la, lb, rr;
    longint maxv, minv, lmax, lmin;
    int sh;
    maxv = (longint'(1) << (W - 1)) - 1;
    minv = -(longint'(1) << (W - 1));
    lmax = (longint'(1) << (L - 1)) - 1;
    lmin = -(longint'(1) << (L - 1));
    sh = int'(y[SHW-1:0]);
    r = '0;
    e = 1'b0;
    case (o)
      3'd0, 3'd1: begin
        s = (o == 3'd0) ? sval(64'(x), W) + sval(64'(y), W) : sval(64'(x), W) - sval(64'(y), W);
        if (s > maxv) begin s = maxv; e = 1'b1; end
        if (s < minv) begin s = minv; e = 1'b1; end
        r = W'(s);
      end
      3'd2: begin
        rr = 0;
        for (int l = 0; l < NL; l++) begin
          la = sval(64'(x) >> (l * L), L);
          lb = sval(64'(y) >> (l * L), L);
          s = la + lb;
          if (s > lmax) begin s = lmax; e = 1'b1; end
          if (s < lmin) begin s = lmin; e = 1'b1; end
          rr = rr | ((s & ((longint'(1) << L) - 1)) << (l * L));
        end
        r = W'(rr);
      end
      3'd3: for (int i = 0; i < W; i++) r[i] = (i >= sh) ? x[i-sh] : 1'b0;
      3'd4: for (int i = 0; i < W; i++) r[i] = (i + sh < W) ? x[i+sh] : x[W-1];
      3'd5: for (int i = 0; i < W; i++) r[i] = x[(i + sh) % W];
      3'd6: begin
        s = 0;
        for (int l = 0; l < NL; l++) s = s + sval(64'(x) >> (l * L), L) + sval(64'(y) >> (l * L), L);
        r = W'(s);
      end
      default: r = x ^ y;
    endcase
  endtask

  // Behavioural model: a RED occupies NL cycles, every other op completes on its accept edge
  int           m_red_left;
  logic         m_valid, m_err;
  logic [W-1:0] m_res, m_red_res;
  logic [2:0]   m_flags;

  always @(posedge clk or negedge rst_n) begin : model
    logic         rdy, fin, e;
    logic [W-1:0] r;
    if (!rst_n) begin
      m_red_left = 0;
      m_valid    = 1'b0;
      m_err      = 1'b0;
      m_res      = '0;
      m_red_res  = '0;
      m_flags    = 3'b000;
    end else begin
      rdy = (m_red_left == 0) && (!m_valid || out_ready);
      fin = 1'b0;
      r   = '0;
      e   = 1'b0;
      if (m_red_left > 0) begin
        m_red_left--;
        if (m_red_left == 0) begin fin = 1'b1; r = m_red_res; end
      end else if (in_valid && rdy) begin
        ref_op(op, a, b, r, e);
        if (op == 3'd6) begin
          m_red_left = NL;
          m_red_res  = r;
        end else begin
          fin = 1'b1;
        end
      end
      if (fin) begin
        m_valid = 1'b1;
        m_res   = r;
        m_err   = e;
        m_flags = {r == '0, e, r[W-1]};
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Continuous comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("in_ready", 32'(in_ready), 32'((m_red_left == 0) && (!m_valid || out_ready)));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("result", 32'(result), 32'(m_res));
    chk("error", 32'(error), 32'(m_err));
    chk("flags", 32'(flags), 32'(m_flags));
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // Issue one op from an idle, drained state and check the literal outcome at its latency
  task automatic do_op(input string name, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic [W-1:0] er, input logic ee,
                       input logic [2:0] ef);
    idle(NL + 2);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    a = ~x;
    b = ~y;
    if (o == 3'd6) begin
      repeat (NL) begin
        @(negedge clk);
        chk({name, " busy_valid"}, 32'(out_valid), 32'd0);
        chk({name, " busy_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk);
      end
    end
    @(negedge clk);
    chk({name, " valid"}, 32'(out_valid), 32'd1);
    chk({name, " result"}, 32'(result), 32'(er));
    chk({name, " error"}, 32'(error), 32'(ee));
    chk({name, " flags"}, 32'(flags), 32'(ef));
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] c [4];
    c[0] = 16'h7FFF; c[1] = 16'h8000; c[2] = 16'h0000; c[3] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return c[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    #12;
    @(negedge clk);
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset flags", 32'(flags), 32'd0);
    rst_n = 1'b1;

    // Literal expectations (flags are {Z,V,N})
    do_op("add_sat", 3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1, 3'b010);
    do_op("sub_sat", 3'd1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 3'b011);
    do_op("padd1",   3'd2, 16'h8009, 16'h9009, 16'h8008, 1'b1, 3'b011);
    do_op("padd2",   3'd2, 16'h0FD8, 16'h0019, 16'h0FE8, 1'b1, 3'b010);
    do_op("padd3",   3'd2, 16'h1234, 16'h1111, 16'h2345, 1'b0, 3'b000);
    do_op("sra",     3'd4, 16'h8000, 16'h0004, 16'hF800, 1'b0, 3'b001);
    do_op("sll",     3'd3, 16'h0001, 16'h000F, 16'h8000, 1'b0, 3'b001);
    do_op("ror",     3'd5, 16'h0001, 16'h0001, 16'h8000, 1'b0, 3'b001);
    do_op("xor",     3'd7, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 3'b100);
    // Lanes are signed: (1+2+3+4) + (5+6+7-8) = 20; eight lanes of -8 = -64
    do_op("red1",    3'd6, 16'h1234, 16'h5678, 16'h0014, 1'b0, 3'b000);
    do_op("red2",    3'd6, 16'h8888, 16'h8888, 16'hFFC0, 1'b0, 3'b001);

    // Backpressure: second ADD waits while the first result is held
    idle(NL + 2);
    @(posedge clk);
    #2;
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; a = 16'h0001; b = 16'h0002;
    @(posedge clk);
    #2;
    a = 16'h0003; b = 16'h0004;
    repeat (3) begin
      @(negedge clk);
      chk("bp ready", 32'(in_ready), 32'd0);
      chk("bp hold", 32'(result), 32'h0003);
      @(posedge clk);
    end
    #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp drain_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp second", 32'(result), 32'h0007);
    chk("bp second_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("bp cleared", 32'(out_valid), 32'd0);

    // Reset two cycles into a reduction
    idle(NL + 2);
    @(posedge clk);
    #2;
    in_valid = 1'b1; op = 3'd6; a = 16'h7777; b = 16'h1111;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst valid", 32'(out_valid), 32'd0);
    chk("rst result", 32'(result), 32'd0);
    chk("rst flags", 32'(flags), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    do_op("add_after_rst", 3'd0, 16'h0005, 16'h0003, 16'h0008, 1'b0, 3'b000);

    // Random traffic; the compare process checks every cycle
    repeat (3000) begin
      @(posedge clk);
      #2;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
    end
    idle(NL + 2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
